// File: rtl/mult_64x64_segmented.sv
// Sequential 64x64 unsigned multiplier: one in_a x SEG_W-bit slice of in_b is accumulated per clock.
// Build option: define MULT_SEG_RESULT_CLEAR_EN to clear result when a new operation is accepted.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accumulating one partial product per cycle, LSB segment first
// DONE  | result valid, done high for this single cycle
module mult_64x64_segmented #(
  parameter int SEG_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [63:0]   in_a,
  input  logic [63:0]   in_b,
  output logic [127:0]  result,
  output logic          done
);

  localparam int N  = 64 / SEG_W;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state;
  logic [63:0]            a_reg;
  logic [63:0]            b_reg;
  logic [127:0]           acc;
  logic [KW-1:0]          k;
  logic [5:0]             seg_off;
  logic [SEG_W-1:0]       seg;
  logic [64+SEG_W-1:0]    pp;
  logic [127:0]           acc_next;
  logic                   last_seg;

  always_comb begin
    seg_off  = 6'(int'(k) * SEG_W);
    seg      = b_reg[seg_off +: SEG_W];
    pp       = {{SEG_W{1'b0}}, a_reg} * {64'd0, seg};
    acc_next = acc + (128'(pp) << seg_off);
    last_seg = (k == KW'(N - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      acc    <= '0;
      k      <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          acc <= acc_next;
          k   <= k + 1'b1;
          if (last_seg) begin
            result <= acc_next;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        default: begin
          // IDLE and DONE accept start identically; done always drops here
          done <= 1'b0;
          if (start) begin
            a_reg <= in_a;
            b_reg <= in_b;
            acc   <= '0;
            k     <= '0;
            state <= RUN;
`ifdef MULT_SEG_RESULT_CLEAR_EN
            result <= '0;
`else
            result <= result;
`endif
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_64x64_segmented.sv
// Directed + random bench for mult_64x64_segmented; expected products queued at start, checked at done.
module tb_mult_64x64_segmented;

  localparam int SEG_W = 16;
  localparam int N     = 64 / SEG_W;

  logic         clk;
  logic         rst;
  logic         start;
  logic [63:0]  in_a;
  logic [63:0]  in_b;
  logic [127:0] result;
  logic         done;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];

  mult_64x64_segmented #(.SEG_W(SEG_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_a(in_a), .in_b(in_b),
    .result(result), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  // drive start for one edge from the current (post-edge) time; operands are scrambled afterwards
  task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic [127:0] exp);
    in_a  = a;
    in_b  = b;
    start = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0;
    in_a  = {$urandom, $urandom};
    in_b  = {$urandom, $urandom};
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 4 * N + 8) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic count_done(input int ncyc, output int pulses);
    pulses = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
  endtask

  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic [127:0] exp,
                       input string tag);
    int cyc;
    start_op(a, b, exp);
    check({tag, "_done_early"}, 128'(done), 0);
    wait_done(cyc);
    check({tag, "_latency"}, 128'(cyc), 128'(N));
    check({tag, "_result"}, result, pop_exp());
    @(posedge clk); #1;
    check({tag, "_done_width"}, 128'(done), 0);
    check({tag, "_result_hold"}, result, exp);
  endtask

  initial begin
    int cyc;
    int pulses;
    logic [63:0] ra;
    logic [63:0] rb;

    rst   = 1'b1;
    start = 1'b0;
    in_a  = '0;
    in_b  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", result, 0);
    check("reset_done", 128'(done), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(64'd0, 64'd0, 128'd0, "zero");
    do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
          128'h3FFF_FFFF_FFFF_FFFF_0000_0000_0000_0001, "max63");
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
          128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, "max64");
    do_op(64'hFF, 64'hFF, 128'hFE01, "seg_lo");
    do_op(64'hFF00, 64'hFF, 128'hFE0100, "seg_byte1");
    do_op(64'hFF00_0000_0000_0000, 64'hFF, 128'hFE01_0000_0000_0000_00, "seg_top");
    do_op(64'h0101_0101_0101_0101, 64'h0101_0101_0101_0101,
          128'h0001_0203_0405_0607_0807_0605_0403_0201, "bytes");

    // start re-asserted during RUN must not disturb the running product
    start_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
             128'(64'h1234_5678_9ABC_DEF0) * 128'(64'h0FED_CBA9_8765_4321));
    @(posedge clk); #1;
    in_a  = 64'hDEAD_BEEF_0000_0001;
    in_b  = 64'h0000_0000_0000_0003;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc);
    check("runstart_latency", 128'(cyc), 128'(N - 2));
    check("runstart_result", result, pop_exp());
    count_done(2 * N + 2, pulses);
    check("runstart_single_done", 128'(pulses), 0);

    // new op accepted in the DONE cycle
    start_op(64'h0000_0001_0000_0003, 64'h0000_0000_0000_0007, 128'h0000_0007_0000_0015);
    wait_done(cyc);
    check("b2b_first_latency", 128'(cyc), 128'(N));
    check("b2b_first_result", result, pop_exp());
    start_op(64'hCAFE_F00D_1234_0000, 64'h0000_0000_0001_0001,
             128'(64'hCAFE_F00D_1234_0000) * 128'(64'h0000_0000_0001_0001));
    check("b2b_done_fall", 128'(done), 0);
    check("b2b_result_held", result, 128'h0000_0007_0000_0015);
    wait_done(cyc);
    check("b2b_second_latency", 128'(cyc), 128'(N));
    check("b2b_second_result", result, pop_exp());
    @(posedge clk); #1;

    // asynchronous reset in the second RUN cycle aborts the op
    in_a  = 64'h5555_5555_5555_5555;
    in_b  = 64'h3333_3333_3333_3333;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_result", result, 0);
    check("abort_done", 128'(done), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    count_done(2 * N + 2, pulses);
    check("abort_no_done", 128'(pulses), 0);

    for (int i = 0; i < 50; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      do_op(ra, rb, 128'(ra) * 128'(rb), "rand");
    end

    check("queue_empty", 128'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_64x64_segmented.md
# mult_64x64_segmented

Sequential 64×64-bit unsigned multiplier producing a full 128-bit product. It splits operand `in_b` into segments and accumulates one `in_a × segment` partial product per clock, trading latency for a small multiplier array. It is a standalone arithmetic block with a single-cycle start / done-pulse handshake, used by datapaths that tolerate multi-cycle multiply latency.

## Interface
- `SEG_W`, default 16: segment width in bits. Legal values are 8, 16, 32 and 64. Segment count is N = 64/SEG_W.
- `clk` input, 1 bit: single clock, rising-edge.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `start` input, 1 bit: starts an operation when sampled high in IDLE or DONE.
- `in_a` input, 64 bits: multiplicand, unsigned, sampled with `start`.
- `in_b` input, 64 bits: multiplier, unsigned, sampled with `start`.
- `result` output, 128 bits: product register; valid while `done`=1 and held afterwards.
- `done` output, 1 bit: registered, one-cycle pulse marking a valid `result`.

## Operation
- The FSM has three states: IDLE, RUN and DONE. Reset state is IDLE.
- In IDLE or DONE with `start`=1, the block:
  - latches `in_a` and `in_b` into internal registers;
  - clears the accumulator;
  - sets segment counter k=0;
  - moves to RUN.
- In RUN, each cycle: acc ← acc + ((a × b[k·SEG_W +: SEG_W]) << (k·SEG_W)), then k ← k+1.
  - Segments are processed LSB first.
  - The partial product is 64+SEG_W bits wide, zero-extended to 128 bits.
  - On the last segment (k=N−1), `result` ← final accumulator value, `done` ← 1, and the FSM moves to DONE.
- In DONE without `start`, the FSM returns to IDLE and `done` ← 0.
- `start` is ignored while in RUN. No queuing, no error flag.
- Arithmetic is unsigned. No overflow is possible, because a 64×64 product always fits in 128 bits.
- `result` holds its value until the next completion (unless `MULT_SEG_RESULT_CLEAR_EN` is defined).
- `in_a`/`in_b` may change freely after the `start` edge; only latched copies are used.

## Timing
- Reset values: `result`=0, `done`=0, state IDLE, k=0, accumulator 0.
- Reset mid-operation aborts immediately and asynchronously. No `done` pulse is produced for the aborted operation.
- Call the edge that samples `start`=1 E0. Accumulation occurs on edges E1..EN.
  - `done` and the final `result` appear after EN.
  - Latency from start to `done` is N cycles (4 at SEG_W=16).
- `done` is high for exactly one cycle, then falls at E(N+1).
- If `start`=1 at E(N+1), a new operation begins at that edge and `done` still falls there.
- Back-to-back throughput is one operation per N+1 cycles.
- `done` is never high during the first cycle after `start` is accepted.

## Configuration
- Macro `MULT_SEG_RESULT_CLEAR_EN`.
- When defined: `result` is cleared to 0 on the edge that accepts `start`, so stale products are never visible during RUN.
- When undefined (default): `result` keeps the previous product until the new one is written at EN.
- `done` timing is identical in both builds.

## Test plan
- After reset, pulse `start` with a=0, b=0. Required: `done` pulses after 4 cycles and `result`=0. Check `result`=0 and `done`=0 during reset.
- a=0x7FFFFFFFFFFFFFFF, b=0x7FFFFFFFFFFFFFFF. Required: `result`=0x3FFFFFFFFFFFFFFF0000000000000001. Also a=0xFFFFFFFFFFFFFFFF, b=0xFFFFFFFFFFFFFFFF. Required: `result`=0xFFFFFFFFFFFFFFFE0000000000000001.
- Segment placement, with b=0xFF:
  - a=0xFF gives 0xFE01.
  - a=0xFF00 gives 0xFE0100.
  - a=0xFF00000000000000 gives 0xFE01 followed by 14 hex zeros.
- a=b=0x0101010101010101. Required: `result`=0x00010203040506070807060504030201.
- Assert `start` again during RUN with different operands. Required: the first product is unaffected and there is exactly one `done` pulse. Start a new op in the DONE cycle. Required: `done` lasts exactly one cycle and the new result follows N+1 cycles later.
- Assert `rst` in the 2nd RUN cycle. Required: `done`=0 and `result`=0 immediately, and no `done` pulse occurs. Then 50 random operand pairs each match the 128-bit reference product.
